// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 responder backed by a word-addressed register memory
// Optional range check: define AXI4_MEM_SLV_RANGE_CHK_EN to flag words at or beyond MEM_DEPTH.
module axi4_mem_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clock,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWLOCK,
    input  logic [3:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic [3:0]              AWQOS,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARLOCK,
    input  logic [3:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic [3:0]              ARQOS,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI4_MEM_SLV_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst,
                                                        input logic [7:0] len);
        logic [ADDR_WIDTH-1:0] incr, aligned, wrap_mask, result;
        incr      = ADDR_WIDTH'(1) << size;
        aligned   = addr & ~(incr - ADDR_WIDTH'(1));
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_INCR: result = aligned + incr;
            BURST_WRAP: result = (addr & ~wrap_mask) | ((aligned + incr) & wrap_mask);
            default:    result = addr;
        endcase
        return result;
    endfunction

    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'(BYTE_LSB)) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        return RANGE_CHK && (|(addr >> (BYTE_LSB + IDX_W)));
    endfunction

    // Write direction
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  wsupp_q, wsupp_d, werr_q, werr_d;
    logic                  mem_we, beat_err;
    logic [IDX_W-1:0]      mem_widx;

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wsupp_d   = wsupp_q;
        werr_d    = werr_q;
        mem_we    = 1'b0;
        beat_err  = 1'b0;
        mem_widx  = waddr_q[BYTE_LSB +: IDX_W];
        case (w_state_q)
            W_IDLE: if (AWVALID && awready_q) begin
                bid_d     = AWID;
                waddr_d   = AWADDR;
                wlen_d    = AWLEN;
                wsize_d   = AWSIZE;
                wburst_d  = AWBURST;
                wcnt_d    = 8'd0;
                wsupp_d   = burst_bad(AWSIZE, AWBURST, AWLEN) || out_of_range(AWADDR);
                werr_d    = wsupp_d;
                w_state_d = W_DATA;
            end
            W_DATA: if (WVALID && wready_q) begin
                // WLAST is only cross-checked; the captured length decides the end of burst
                beat_err = (WLAST != (wcnt_q == wlen_q)) || out_of_range(waddr_q);
                mem_we   = !wsupp_q && !out_of_range(waddr_q);
                waddr_d  = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                wcnt_d   = wcnt_q + 8'd1;
                werr_d   = werr_q || beat_err;
                if (wcnt_q == wlen_q) begin
                    bresp_d   = (werr_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) mem[mem_widx][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    // Read direction
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rerr_q, rerr_d, rd_load, rd_bad;
    logic [IDX_W-1:0]      rd_idx;

    always_comb begin
        r_state_d = r_state_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rd_load   = 1'b0;
        rd_bad    = rerr_q;
        rd_idx    = raddr_q[BYTE_LSB +: IDX_W];
        case (r_state_q)
            R_IDLE: if (ARVALID && arready_q) begin
                rd_load   = 1'b1;
                rd_idx    = ARADDR[BYTE_LSB +: IDX_W];
                rerr_d    = burst_bad(ARSIZE, ARBURST, ARLEN) || out_of_range(ARADDR);
                rd_bad    = rerr_d;
                rid_d     = ARID;
                rlen_d    = ARLEN;
                rsize_d   = ARSIZE;
                rburst_d  = ARBURST;
                rcnt_d    = 8'd0;
                rlast_d   = (ARLEN == 8'd0);
                raddr_d   = next_addr(ARADDR, ARSIZE, ARBURST, ARLEN);
                r_state_d = R_DATA;
            end
            R_DATA: if (RREADY && rvalid_q) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    rd_load = 1'b1;
                    rd_bad  = rerr_q || out_of_range(raddr_q);
                    rcnt_d  = rcnt_q + 8'd1;
                    rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load) begin
            rdata_d = rd_bad ? '0 : mem[rd_idx];
            rresp_d = rd_bad ? RESP_SLVERR : RESP_OKAY;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge clock or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wsupp_q   <= 1'b0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wsupp_q   <= wsupp_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
        end
    end

    logic unused_sideband;
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, ARLOCK, ARCACHE, ARPROT, ARQOS};

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
endmodule

// File: doc/axi4_mem_slave.md
# axi4_mem_slave

AXI4 slave (responder) backed by an internal word-addressed register memory. It is the far end of the AXI4 bus driven by the team's masters and test sequences. It accepts one write burst and one read burst at a time, and the two directions run independently. It supports FIXED, INCR and WRAP bursts with byte strobes and returns OKAY/SLVERR responses.

## Interface
- ID_WIDTH, 4, width of AWID/BID/ARID/RID
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width in bits (32/64/128)
- MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two
- clock  in  1  single clock; all logic on rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- AW channel: AWID, AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWLOCK, AWCACHE[3:0], AWPROT[2:0], AWQOS[3:0], AWVALID  in; AWREADY  out
- W channel: WDATA, WSTRB[DATA_WIDTH/8], WLAST, WVALID  in; WREADY  out
- B channel: BID, BRESP[1:0], BVALID  out; BREADY  in
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID  in; ARREADY  out
- R channel: RID, RDATA, RRESP[1:0], RLAST, RVALID  out; RREADY  in
- LOCK/CACHE/PROT/QOS are accepted and ignored.

## Operation
- Write FSM has three states: W_IDLE, W_DATA and W_RESP.
  - W_IDLE: AWREADY=1. On the AW handshake, capture ID, address, length, size and burst type, clear the beat counter, and go to W_DATA.
  - W_DATA: WREADY=1. Each accepted beat writes the enabled bytes at the current word (WSTRB bit i → byte i), then advances the address.
  - After beat AWLEN+1 is accepted, go to W_RESP. The beat count is authoritative.
  - W_RESP: BVALID=1, BID=captured ID. On the B handshake, go to W_IDLE.
- Read FSM has two states: R_IDLE and R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, load RDATA from the first address, set RVALID=1, and go to R_DATA.
  - R_DATA: on each R handshake, load the next beat. RLAST=1 on beat ARLEN+1. The R handshake on the last beat returns the FSM to R_IDLE with RVALID=0.
- RDATA/RID/RRESP/RLAST are registered and stay stable while RVALID=1 and RREADY=0.
- Address rules:
  - Word index = addr >> log2(DATA_WIDTH/8), modulo MEM_DEPTH.
  - FIXED: address constant.
  - INCR: next = (addr aligned to size) + (1<<size).
  - WRAP: same increment, wrapping within a (LEN+1)<<size byte boundary aligned block.
- Errors return SLVERR (2'b10) in these cases:
  - size > log2(DATA_WIDTH/8);
  - burst type 2'b11;
  - WRAP with LEN not in {1,3,7,15};
  - WLAST value mismatching the beat count.
- Error handling per direction:
  - Size, burst-type and WRAP-length errors suppress every memory write of that burst. All beats are still accepted.
  - For those same errors on a read, every beat returns SLVERR with RDATA=0.
  - A WLAST mismatch does not suppress writes; it only flags BRESP=SLVERR.
- Read and write to the same word in the same cycle: the read register captures the old data.
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0. AWREADY/ARREADY rise on the first clock after deassertion. Memory contents are not reset.
- ARESETn asserted mid-burst: both FSMs return to IDLE immediately. Outstanding transactions are dropped; bytes already written remain.

## Timing
- AW handshake in cycle N → WREADY=1 from N+1. AWREADY=0 from N+1 until the B handshake.
- Last W beat accepted in cycle M → BVALID=1 in M+1.
- AR handshake in cycle N → RVALID=1 with beat 0 in N+1.
- Throughput is one beat per cycle on W and R with no bubbles.
- Write burst to B handshake with BREADY held high: LEN+3 cycles minimum.
- Both directions may be active in the same cycle with no interaction.

## Configuration
- AXI4_MEM_SLV_RANGE_CHK_EN defined: every burst whose start word ≥ MEM_DEPTH returns SLVERR.
  - For writes, no memory write occurs for that burst.
  - For reads, RDATA=0.
  - Later beats that cross MEM_DEPTH are flagged individually.
- AXI4_MEM_SLV_RANGE_CHK_EN undefined: word index wraps modulo MEM_DEPTH and all in-protocol accesses return OKAY.

## Test plan
- INCR write AWADDR=0x10, LEN=3, size=2, data 0xA0..0xA3, strobe 0xF; then an INCR read of the same range → read returns 0xA0..0xA3, RLAST on beat 3, BRESP=RRESP=OKAY, IDs echoed.
- WRAP read ARADDR=0x38, LEN=3, size=2 (16-byte block 0x30) → beats are read from 0x38, 0x3C, 0x30, 0x34.
- Narrow write WSTRB=0x2 with WDATA=0xDEADBEEF onto a word holding 0x00000000 → the word then reads back 0x0000BE00.
- Read with RREADY held low for 5 cycles on beat 1 → RDATA/RLAST stable for all stalled cycles. Concurrent with this, a write burst completes with BRESP=OKAY.
- AWSIZE=3 on 32-bit data, and separately WLAST high on beat 0 of a LEN=1 burst:
  - the AWSIZE=3 burst returns BRESP=SLVERR and memory is unchanged;
  - the early-WLAST burst returns BRESP=SLVERR, two beats are accepted, and both beats are written.
- ARESETn pulsed low during W_DATA → within that cycle WREADY=0 and BVALID=0. After release, AWREADY=1 and a fresh burst completes normally.
